// File: rtl/timer_irq_ctrl.sv
// rtl/timer_irq_ctrl.sv - timer overflow interrupt latch, timestamp, epoch and miss counter
//
// Purpose:
//   Receives the one-cycle overflow pulse of a free-running timer and turns it
//   into a level interrupt held until the CPU acknowledges it. On each latch the
//   live timer count is captured as a timestamp. Every overflow pulse advances
//   an epoch counter that extends the timer. Overflows that arrive while an
//   interrupt is still outstanding are counted in a saturating miss counter.
//
// Ports:
//   clk        in   1        single clock, rising edge
//   reset      in   1        asynchronous, active-high; clears all state
//   irq_timer  in   1        overflow pulse from the timer (each high cycle counts)
//   timer_cnt  in   CNT_W    live timer count
//   irq_en     in   1        enables new latches only
//   irq_ack    in   1        CPU acknowledge, honoured only while pending
//   irq_out    out  1        level interrupt to the CPU
//   stamp      out  CNT_W    timer_cnt captured at latch
//   epoch      out  EPOCH_W  total overflow pulses seen (wraps)
//   miss_cnt   out  MISS_W   overflows lost while pending/acking (saturates)
//   state      out  2        debug: 00 IDLE, 01 PEND, 10 ACK

module timer_irq_ctrl #(
  parameter int CNT_W   = 32,
  parameter int EPOCH_W = 32,
  parameter int MISS_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               irq_timer,
  input  logic [CNT_W-1:0]   timer_cnt,
  input  logic               irq_en,
  input  logic               irq_ack,
  output logic               irq_out,
  output logic [CNT_W-1:0]   stamp,
  output logic [EPOCH_W-1:0] epoch,
  output logic [MISS_W-1:0]  miss_cnt,
  output logic [1:0]         state
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_PEND = 2'b01;
  localparam logic [1:0] S_ACK  = 2'b10;

  localparam logic [EPOCH_W-1:0] EPOCH_ONE = EPOCH_W'(1);
  localparam logic [MISS_W-1:0]  MISS_ONE  = MISS_W'(1);
  localparam logic [MISS_W-1:0]  MISS_MAX  = {MISS_W{1'b1}};

  logic [1:0]         state_q,    state_d;
  logic               irq_q,      irq_d;
  logic [CNT_W-1:0]   stamp_q,    stamp_d;
  logic [EPOCH_W-1:0] epoch_q,    epoch_d;
  logic [MISS_W-1:0]  miss_q,     miss_d;
  logic               miss_event;

  always_comb begin
    state_d    = state_q;
    irq_d      = irq_q;
    stamp_d    = stamp_q;
    miss_event = 1'b0;

    // The epoch counts every sampled pulse independent of state and enable.
    epoch_d = irq_timer ? (epoch_q + EPOCH_ONE) : epoch_q;

    case (state_q)
      S_IDLE: begin
        irq_d = 1'b0;
        if (irq_timer && irq_en) begin
          state_d = S_PEND;
          stamp_d = timer_cnt;
          irq_d   = 1'b1;
        end
      end
      S_PEND: begin
        // Dropping irq_en here is deliberately ignored: only an ack clears it.
        irq_d = 1'b1;
        if (irq_timer) begin
          miss_event = 1'b1;
        end
        if (irq_ack) begin
          state_d = S_ACK;
          irq_d   = 1'b0;
        end
      end
      S_ACK: begin
        // One-cycle gap so software sees the line drop before a re-latch.
        irq_d   = 1'b0;
        state_d = S_IDLE;
        if (irq_timer) begin
          miss_event = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        irq_d   = 1'b0;
      end
    endcase

    miss_d = (miss_event && (miss_q != MISS_MAX)) ? (miss_q + MISS_ONE) : miss_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      irq_q   <= 1'b0;
      stamp_q <= '0;
      epoch_q <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      stamp_q <= stamp_d;
      epoch_q <= epoch_d;
      miss_q  <= miss_d;
    end
  end

  assign irq_out  = irq_q;
  assign stamp    = stamp_q;
  assign epoch    = epoch_q;
  assign miss_cnt = miss_q;
  assign state    = state_q;

endmodule
